// File: rtl/rx_pkt_fifo_pkg.sv
// Shared defaults, write-side FSM encoding and pipe word field offsets
// for the store-and-forward receive packet FIFO.
package rx_pkt_fifo_pkg;

  localparam int N_DEF     = 32;
  localparam int S_DEF     = N_DEF / 8;
  localparam int D_DEF     = N_DEF + S_DEF + 1;
  localparam int DEPTH_DEF = 128;
  localparam int D_S_DEF   = 7;
  localparam int CW_DEF    = 16;

  // Pipe word layout: {last, keep[S-1:0], data[N-1:0]}
  localparam int LAST_BIT  = N_DEF + S_DEF;
  localparam int KEEP_LSB  = N_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DROP = 2'd2
  } wr_state_t;

endpackage

// File: rtl/rx_pkt_fifo_mem.sv
// Simple dual-port RAM: one write port, one synchronous read port.
// The read register only changes when re is high, so it holds its word
// while the consumer side is stalled.
module rx_pkt_fifo_mem #(
  parameter int W     = 37,
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/rx_pkt_fifo.sv
// Store-and-forward receive FIFO between MAC AXI-stream RX and the NIC pipe.
// Beats are written tentatively at wr_ptr; a clean tlast commits them by
// moving cm_ptr, a bad tlast or overflow rewinds wr_ptr to cm_ptr.
// The read side only sees [rd_ptr, cm_ptr).
//
// Output handshake: pipe_write_req is the valid; a word transfers on a
// rising edge where req & ack are both high. While req=1 and ack=0 the word
// and req are held. ack while req=0 has no effect.
module rx_pkt_fifo
  import rx_pkt_fifo_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int S     = N / 8,
  parameter int D     = N + S + 1,
  parameter int DEPTH = DEPTH_DEF,
  parameter int D_S   = D_S_DEF,
  parameter int CW    = CW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  output logic          rx_axis_resetn,
  input  logic [N-1:0]  rx_axis_tdata,
  input  logic [S-1:0]  rx_axis_tkeep,
  input  logic          rx_axis_tvalid,
  input  logic          rx_axis_tuser,
  input  logic          rx_axis_tlast,
  output logic [D-1:0]  pipe_write_data,
  output logic          pipe_write_req,
  input  logic          pipe_write_ack,
  output logic [CW-1:0] frame_count,
  output logic [CW-1:0] drop_count,
  output logic [D_S:0]  fifo_level,
  output wr_state_t     wr_state
);

  localparam logic [D_S:0] DEPTH_W = (D_S + 1)'(DEPTH);

  wr_state_t    state, state_n;
  logic [D_S:0] wr_ptr, wr_ptr_n;
  logic [D_S:0] cm_ptr, cm_ptr_n;
  logic [D_S:0] rd_ptr;     // oldest word not yet transferred
  logic [D_S:0] fp;         // next word to fetch from RAM
  logic         full;
  logic         we, frame_inc, drop_inc;
  logic         s1_v;       // RAM read register holds a fetched word
  logic         out_fire, s1_move, re;
  logic [D-1:0] mem_rdata;

  // Occupancy counts words until they leave through the handshake, so a
  // word sitting in the output stages still blocks its RAM slot.
  assign fifo_level = wr_ptr - rd_ptr;
  assign full       = (fifo_level == DEPTH_W);
  assign wr_state   = state;

  // Write FSM: next state, pointer updates and counter strobes
  always_comb begin
    state_n   = state;
    wr_ptr_n  = wr_ptr;
    cm_ptr_n  = cm_ptr;
    we        = 1'b0;
    frame_inc = 1'b0;
    drop_inc  = 1'b0;
    if (rx_axis_tvalid) begin
      case (state)
        IDLE, RECV: begin
          if (full) begin
            wr_ptr_n = cm_ptr;
            drop_inc = 1'b1;
            state_n  = rx_axis_tlast ? IDLE : DROP;
          end else begin
            we       = 1'b1;
            wr_ptr_n = wr_ptr + 1'b1;
            state_n  = RECV;
            if (rx_axis_tlast) begin
              state_n = IDLE;
              if (rx_axis_tuser) begin
                wr_ptr_n = cm_ptr;
                drop_inc = 1'b1;
              end else begin
                cm_ptr_n  = wr_ptr + 1'b1;
                frame_inc = 1'b1;
              end
            end
          end
        end
        DROP: begin
          if (rx_axis_tlast) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Write-side state, pointers and frame/drop counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      cm_ptr      <= '0;
      frame_count <= '0;
      drop_count  <= '0;
    end else begin
      state  <= state_n;
      wr_ptr <= wr_ptr_n;
      cm_ptr <= cm_ptr_n;
      if (frame_inc) frame_count <= frame_count + 1'b1;
      if (drop_inc)  drop_count  <= drop_count + 1'b1;
    end
  end

  // MAC RX side comes out of reset one cycle after this block
  always_ff @(posedge clk) begin
    rx_axis_resetn <= ~reset;
  end

  // Two-stage read pipeline: RAM read register feeds the output register.
  // A fetch is issued whenever committed data is pending and the RAM
  // register is empty or being emptied, giving one word per cycle with
  // ack held high.
  assign out_fire = pipe_write_req & pipe_write_ack;
  assign s1_move  = s1_v & (~pipe_write_req | pipe_write_ack);
  assign re       = (fp != cm_ptr) & (~s1_v | s1_move);

  rx_pkt_fifo_mem #(
    .W     (D),
    .DEPTH (DEPTH),
    .AW    (D_S)
  ) u_mem (
    .clk   (clk),
    .we    (we & ~reset),
    .waddr (wr_ptr[D_S-1:0]),
    .wdata ({rx_axis_tlast, rx_axis_tkeep, rx_axis_tdata}),
    .re    (re),
    .raddr (fp[D_S-1:0]),
    .rdata (mem_rdata)
  );

  // Read pointers, stage valid flags and output word register
  always_ff @(posedge clk) begin
    if (reset) begin
      fp              <= '0;
      rd_ptr          <= '0;
      s1_v            <= 1'b0;
      pipe_write_req  <= 1'b0;
      pipe_write_data <= '0;
    end else begin
      if (re)       fp     <= fp + 1'b1;
      if (out_fire) rd_ptr <= rd_ptr + 1'b1;
      if (re)           s1_v <= 1'b1;
      else if (s1_move) s1_v <= 1'b0;
      if (s1_move) begin
        pipe_write_req  <= 1'b1;
        pipe_write_data <= mem_rdata;
      end else if (out_fire) begin
        pipe_write_req  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rx_pkt_fifo.sv
// Directed bench for rx_pkt_fifo: a beat table with per-beat expected
// level/counters, hand-written sequences for latency, overflow, stall,
// fill/drain and mid-frame reset, and an in-order output scoreboard.
module tb_rx_pkt_fifo;
  import rx_pkt_fifo_pkg::*;

  localparam int N  = 32;
  localparam int S  = 4;
  localparam int D  = 37;
  localparam int DS = 7;
  localparam int CW = 16;

  logic          clk;
  logic          reset;
  logic          rx_axis_resetn;
  logic [N-1:0]  rx_axis_tdata;
  logic [S-1:0]  rx_axis_tkeep;
  logic          rx_axis_tvalid;
  logic          rx_axis_tuser;
  logic          rx_axis_tlast;
  logic [D-1:0]  pipe_write_data;
  logic          pipe_write_req;
  logic          pipe_write_ack;
  logic [CW-1:0] frame_count;
  logic [CW-1:0] drop_count;
  logic [DS:0]   fifo_level;
  wr_state_t     wr_state;

  int n_vec = 0;
  int n_err = 0;
  logic [D-1:0] exp_q[$];

  rx_pkt_fifo dut (
    .clk             (clk),
    .reset           (reset),
    .rx_axis_resetn  (rx_axis_resetn),
    .rx_axis_tdata   (rx_axis_tdata),
    .rx_axis_tkeep   (rx_axis_tkeep),
    .rx_axis_tvalid  (rx_axis_tvalid),
    .rx_axis_tuser   (rx_axis_tuser),
    .rx_axis_tlast   (rx_axis_tlast),
    .pipe_write_data (pipe_write_data),
    .pipe_write_req  (pipe_write_req),
    .pipe_write_ack  (pipe_write_ack),
    .frame_count     (frame_count),
    .drop_count      (drop_count),
    .fifo_level      (fifo_level),
    .wr_state        (wr_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    rx_axis_tvalid = 1'b0;
    pipe_write_ack = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [D-1:0] mk_word(input logic l, input logic [S-1:0] k, input logic [N-1:0] d);
    return {l, k, d};
  endfunction

  // ---------------- driver ----------------
  task automatic send_beat(input logic [N-1:0] d, input logic [S-1:0] k,
                           input logic l, input logic u, input logic push);
    rx_axis_tvalid = 1'b1;
    rx_axis_tdata  = d;
    rx_axis_tkeep  = k;
    rx_axis_tlast  = l;
    rx_axis_tuser  = u;
    if (push) exp_q.push_back(mk_word(l, k, d));
    tick();
    rx_axis_tvalid = 1'b0;
    rx_axis_tlast  = 1'b0;
    rx_axis_tuser  = 1'b0;
  endtask

  task automatic drain(input int bound, input logic toggle);
    pipe_write_ack = 1'b1;
    for (int k = 0; k < bound; k++) begin
      if (exp_q.size() == 0 && !pipe_write_req) break;
      tick();
      if (toggle) pipe_write_ack = ~pipe_write_ack;
    end
    pipe_write_ack = 1'b0;
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    chk("drain_req", 64'(pipe_write_req), 64'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  // Sampled at negedge: req & ack here means a transfer on the next posedge.
  logic         prev_stall = 1'b0;
  logic [D-1:0] prev_data  = '0;

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_req", 64'(pipe_write_req), 64'd1);
        chk("hold_data", 64'(pipe_write_data), 64'(prev_data));
      end
      if (pipe_write_req && pipe_write_ack) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL xfer_extra: got %h expected none", pipe_write_data);
        end else begin
          chk("xfer", 64'(pipe_write_data), 64'(exp_q.pop_front()));
        end
      end
      prev_stall = pipe_write_req && !pipe_write_ack;
      prev_data  = pipe_write_data;
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [N-1:0]  data;
    logic [S-1:0]  keep;
    logic          last;
    logic          user;
    logic          push;
    logic [DS:0]   exp_level;
    logic [CW-1:0] exp_frames;
    logic [CW-1:0] exp_drops;
  } vec_t;

  vec_t vecs[8];

  initial begin
    // bad 4-beat frame, then good 2-beat, good 1-beat, bad 1-beat (ack=0)
    vecs[0] = '{32'hA000_0001, 4'hF, 1'b0, 1'b0, 1'b0, 8'd1, 16'd0, 16'd0};
    vecs[1] = '{32'hA000_0002, 4'hF, 1'b0, 1'b0, 1'b0, 8'd2, 16'd0, 16'd0};
    vecs[2] = '{32'hA000_0003, 4'hF, 1'b0, 1'b0, 1'b0, 8'd3, 16'd0, 16'd0};
    vecs[3] = '{32'hA000_0004, 4'hF, 1'b1, 1'b1, 1'b0, 8'd0, 16'd0, 16'd1};
    vecs[4] = '{32'hB000_0001, 4'h3, 1'b0, 1'b0, 1'b1, 8'd1, 16'd0, 16'd1};
    vecs[5] = '{32'hB000_0002, 4'hF, 1'b1, 1'b0, 1'b1, 8'd2, 16'd1, 16'd1};
    vecs[6] = '{32'hC000_0001, 4'h1, 1'b1, 1'b0, 1'b1, 8'd3, 16'd2, 16'd1};
    vecs[7] = '{32'hD000_0001, 4'hF, 1'b1, 1'b1, 1'b0, 8'd3, 16'd2, 16'd2};

    reset          = 1'b1;
    rx_axis_tvalid = 1'b0;
    rx_axis_tdata  = '0;
    rx_axis_tkeep  = '0;
    rx_axis_tlast  = 1'b0;
    rx_axis_tuser  = 1'b0;
    pipe_write_ack = 1'b0;

    // ---- reset state ----
    tick();
    tick();
    chk("rst_req", 64'(pipe_write_req), 64'd0);
    chk("rst_data", 64'(pipe_write_data), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_frames", 64'(frame_count), 64'd0);
    chk("rst_drops", 64'(drop_count), 64'd0);
    chk("rst_resetn", 64'(rx_axis_resetn), 64'd0);
    chk("rst_state", 64'(wr_state), 64'(IDLE));
    reset = 1'b0;
    tick();
    chk("resetn_release", 64'(rx_axis_resetn), 64'd1);

    // ---- test 1: 3-beat frame, ack held high, consecutive output ----
    begin
      logic [D-1:0] t1_exp[3];
      t1_exp[0] = 37'h0F_0000_0001;
      t1_exp[1] = 37'h0F_0000_0002;
      t1_exp[2] = 37'h1F_0000_0003;
      pipe_write_ack = 1'b1;
      send_beat(32'd1, 4'hF, 1'b0, 1'b0, 1'b1);
      send_beat(32'd2, 4'hF, 1'b0, 1'b0, 1'b1);
      send_beat(32'd3, 4'hF, 1'b1, 1'b0, 1'b1);
      for (int k = 0; k < 3 && !pipe_write_req; k++) tick();
      for (int i = 0; i < 3; i++) begin
        chk("t1_req", 64'(pipe_write_req), 64'd1);
        chk("t1_word", 64'(pipe_write_data), 64'(t1_exp[i]));
        tick();
      end
      chk("t1_req_drop", 64'(pipe_write_req), 64'd0);
      chk("t1_frames", 64'(frame_count), 64'd1);
      chk("t1_drops", 64'(drop_count), 64'd0);
      pipe_write_ack = 1'b0;
    end

    // ---- test 2: table-driven bad/good frames ----
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send_beat(vecs[i].data, vecs[i].keep, vecs[i].last, vecs[i].user, vecs[i].push);
      chk("tbl_level", 64'(fifo_level), 64'(vecs[i].exp_level));
      chk("tbl_frames", 64'(frame_count), 64'(vecs[i].exp_frames));
      chk("tbl_drops", 64'(drop_count), 64'(vecs[i].exp_drops));
      if (i < 4) chk("tbl_no_req", 64'(pipe_write_req), 64'd0);
    end
    drain(20, 1'b0);
    chk("t2_level", 64'(fifo_level), 64'd0);

    // ---- test 3: 130-beat oversize frame, then 4-beat frame ----
    do_reset();
    for (int i = 1; i <= 130; i++) begin
      send_beat(32'(3 + i), 4'hF, (i == 130), 1'b0, 1'b0);
      if (i == 128) chk("t3_full_level", 64'(fifo_level), 64'd128);
      if (i == 129) begin
        chk("t3_drop_cnt", 64'(drop_count), 64'd1);
        chk("t3_drop_level", 64'(fifo_level), 64'd0);
        chk("t3_drop_state", 64'(wr_state), 64'(DROP));
      end
    end
    chk("t3_tail_state", 64'(wr_state), 64'(IDLE));
    chk("t3_tail_drops", 64'(drop_count), 64'd1);
    chk("t3_tail_level", 64'(fifo_level), 64'd0);
    for (int i = 0; i < 4; i++) send_beat(32'h3000_0000 + 32'(i), 4'hF, (i == 3), 1'b0, 1'b1);
    chk("t3_frames", 64'(frame_count), 64'd1);
    drain(20, 1'b0);

    // ---- test 4: two 3-beat frames, ack toggling ----
    do_reset();
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 3; i++)
        send_beat(32'h4000_0000 + 32'(f * 16 + i), 4'hF, (i == 2), 1'b0, 1'b1);
    chk("t4_level", 64'(fifo_level), 64'd6);
    chk("t4_frames", 64'(frame_count), 64'd2);
    drain(40, 1'b1);

    // ---- test 5: fill with two 64-beat frames, overflow, drain ----
    do_reset();
    for (int f = 1; f <= 2; f++)
      for (int i = 0; i < 64; i++)
        send_beat((32'(f) << 16) + 32'(i), 4'hF, (i == 63), 1'b0, 1'b1);
    chk("t5_level_full", 64'(fifo_level), 64'd128);
    chk("t5_frames", 64'(frame_count), 64'd2);
    send_beat(32'h5555_5555, 4'hF, 1'b1, 1'b0, 1'b0);
    chk("t5_drops", 64'(drop_count), 64'd1);
    chk("t5_level_after", 64'(fifo_level), 64'd128);
    chk("t5_state", 64'(wr_state), 64'(IDLE));
    drain(200, 1'b0);
    chk("t5_level_empty", 64'(fifo_level), 64'd0);

    // ---- test 6: reset during beat 2 of a frame ----
    pipe_write_ack = 1'b1;
    send_beat(32'h0000_0061, 4'hF, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    send_beat(32'h0000_0062, 4'hF, 1'b0, 1'b0, 1'b0);
    chk("t6_req", 64'(pipe_write_req), 64'd0);
    chk("t6_frames", 64'(frame_count), 64'd0);
    chk("t6_drops", 64'(drop_count), 64'd0);
    chk("t6_level", 64'(fifo_level), 64'd0);
    chk("t6_resetn_low", 64'(rx_axis_resetn), 64'd0);
    reset = 1'b0;
    tick();
    chk("t6_resetn_high", 64'(rx_axis_resetn), 64'd1);
    chk("t6_level_clear", 64'(fifo_level), 64'd0);
    for (int i = 1; i <= 3; i++) send_beat(32'h0000_0070 + 32'(i), 4'hF, (i == 3), 1'b0, 1'b1);
    drain(20, 1'b0);
    chk("t6_frames_after", 64'(frame_count), 64'd1);

    // ---- report ----
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
